// File: rtl/rsa_result_serializer.sv
// rsa_result_serializer: captures one wide RSA result and hands it to polled software as 32-bit words, LSW first.
module rsa_result_serializer #(
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              result_valid,
  input  logic [DATA_W-1:0] result_data,
  output logic              result_ready,
  output logic [31:0]       to_sw_port,
  output logic [1:0]        to_sw_sig,
  input  logic [1:0]        to_hw_sig,
  output logic [(DATA_W/32 > 1 ? $clog2(DATA_W/32) : 1)-1:0] word_idx
);
  localparam int NUM_WORDS = DATA_W / 32;
  localparam int IW = NUM_WORDS > 1 ? $clog2(NUM_WORDS) : 1;
  typedef enum logic [1:0] {IDLE, PRESENT, RELEASE, DONE} state_t;
  state_t state_q, state_d;
  logic [DATA_W-1:0] cap_q, cap_d;
  logic [31:0] port_q, port_d;
  logic [1:0] sig_q, sig_d;
  logic [IW-1:0] idx_q, idx_d, nxt_idx;
  logic ready_q, ready_d;
  logic last;
  always_comb begin
    state_d = state_q;
    cap_d = cap_q;
    port_d = port_q;
    idx_d = idx_q;
    nxt_idx = idx_q + 1'b1;
    last = idx_q == IW'(NUM_WORDS - 1);
    if (to_hw_sig == 2'b11) begin
      state_d = IDLE;
      cap_d = '0;
      port_d = '0;
      idx_d = '0;
    end else begin
      case (state_q)
        IDLE: if (result_valid && ready_q && to_hw_sig == 2'b00) begin
          state_d = PRESENT;
          cap_d = result_data;
          port_d = result_data[31:0];
          idx_d = '0;
        end
        PRESENT: if (to_hw_sig == 2'b01) state_d = RELEASE;
        RELEASE: if (to_hw_sig == 2'b00) begin
          if (last) state_d = DONE;
          else begin
            state_d = PRESENT;
            idx_d = nxt_idx;
            port_d = cap_q[{nxt_idx, 5'd0} +: 32];
          end
        end
        DONE: if (to_hw_sig == 2'b10) begin
          state_d = IDLE;
          cap_d = '0;
          port_d = '0;
          idx_d = '0;
        end
        default: state_d = IDLE;
      endcase
    end
    sig_d = state_d == PRESENT ? 2'b01 : state_d == DONE ? 2'b10 : 2'b00;
    // Re-arm only once software has returned its command to idle.
    ready_d = state_d == IDLE && to_hw_sig == 2'b00;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cap_q <= '0;
      port_q <= '0;
      sig_q <= 2'b00;
      idx_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cap_q <= cap_d;
      port_q <= port_d;
      sig_q <= sig_d;
      idx_q <= idx_d;
      ready_q <= ready_d;
    end
  end
  assign result_ready = ready_q;
  assign to_sw_port = port_q;
  assign to_sw_sig = sig_q;
  assign word_idx = idx_q;
endmodule

// File: tb/tb_rsa_result_serializer.sv
// tb_rsa_result_serializer: directed software-handshake scenarios with a per-cycle word/stability monitor.
module tb_rsa_result_serializer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic result_valid = 1'b0;
  logic [127:0] result_data = '0;
  logic result_ready;
  logic [31:0] to_sw_port;
  logic [1:0] to_sw_sig;
  logic [1:0] to_hw_sig = 2'b00;
  logic [1:0] word_idx;
  int n_tests = 0;
  int n_fail = 0;
  logic mon_en = 1'b0;
  logic [127:0] exp_res = '0;
  logic [31:0] pport = '0;
  logic [1:0] psig = 2'b00;
  rsa_result_serializer #(.DATA_W(128)) dut (
    .clk(clk), .reset_n(reset_n), .result_valid(result_valid), .result_data(result_data),
    .result_ready(result_ready), .to_sw_port(to_sw_port), .to_sw_sig(to_sw_sig),
    .to_hw_sig(to_hw_sig), .word_idx(word_idx)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_sig(input string name, input logic [1:0] s);
    for (int i = 0; i < 300 && to_sw_sig !== s; i++) tick();
    chk(name, {30'd0, to_sw_sig}, {30'd0, s});
  endtask
  // Words shown while 01 must be the captured result's word at word_idx and never move mid-presentation.
  always @(negedge clk) begin
    if (mon_en) begin
      if (to_sw_sig == 2'b01) begin
        chk("mon_word", to_sw_port, exp_res[32*word_idx +: 32]);
        if (psig == 2'b01) chk("mon_stable", to_sw_port, pport);
      end
      if (to_sw_sig == 2'b10) chk("mon_last", to_sw_port, exp_res[127:96]);
      pport = to_sw_port;
      psig = to_sw_sig;
    end
  end
  task automatic send(input logic [127:0] d);
    for (int i = 0; i < 300 && !result_ready; i++) tick();
    chk("send_ready", {31'd0, result_ready}, 32'd1);
    exp_res = d;
    result_data = d;
    result_valid = 1'b1;
    tick();
    result_valid = 1'b0;
    chk("lat_sig", {30'd0, to_sw_sig}, 32'd1);
    chk("lat_word0", to_sw_port, d[31:0]);
  endtask
  task automatic read_word(input int k, input int dly);
    wait_sig("wait_present", 2'b01);
    chk("word_val", to_sw_port, exp_res[32*k +: 32]);
    chk("word_idx", {30'd0, word_idx}, k[31:0]);
    repeat (dly) tick();
    to_hw_sig = 2'b01;
    tick();
    wait_sig("wait_release", 2'b00);
    chk("release_port", to_sw_port, exp_res[32*k +: 32]);
    to_hw_sig = 2'b00;
    tick();
  endtask
  task automatic finish_done();
    wait_sig("wait_done", 2'b10);
    chk("done_port", to_sw_port, exp_res[127:96]);
    to_hw_sig = 2'b10;
    tick();
    chk("idle_sig", {30'd0, to_sw_sig}, 32'd0);
    chk("idle_port", to_sw_port, 32'd0);
    chk("idle_idx", {30'd0, word_idx}, 32'd0);
    chk("idle_ready_stale", {31'd0, result_ready}, 32'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int i = 0; i < 3; i++) begin
      result_valid = 1'($urandom);
      result_data = {$urandom, $urandom, $urandom, $urandom};
      to_hw_sig = 2'($urandom);
      tick();
      chk("rst_port", to_sw_port, 32'd0);
      chk("rst_sig", {30'd0, to_sw_sig}, 32'd0);
      chk("rst_idx", {30'd0, word_idx}, 32'd0);
      chk("rst_ready", {31'd0, result_ready}, 32'd0);
    end
    result_valid = 1'b0;
    to_hw_sig = 2'b00;
    reset_n = 1'b1;
    chk("rel_ready0", {31'd0, result_ready}, 32'd0);
    tick();
    chk("rel_ready1", {31'd0, result_ready}, 32'd1);
    mon_en = 1'b1;
    // Full transfer with one long software delay.
    send(128'h44444444_33333333_22222222_11111111);
    chk("lit_w0", to_sw_port, 32'h11111111);
    read_word(0, 0);
    read_word(1, 50);
    chk("lit_w2", to_sw_port, 32'h33333333);
    read_word(2, 3);
    read_word(3, 1);
    chk("lit_done_sig", {30'd0, to_sw_sig}, 32'd2);
    chk("lit_w3", to_sw_port, 32'h44444444);
    finish_done();
    to_hw_sig = 2'b00;
    tick();
    chk("rearm_ready", {31'd0, result_ready}, 32'd1);
    // Collision: a second result mid-transfer must be dropped.
    send(128'h89abcdef_01234567_fedcba98_76543210);
    read_word(0, 2);
    result_data = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
    result_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("coll_ready", {31'd0, result_ready}, 32'd0);
    end
    result_valid = 1'b0;
    read_word(1, 1);
    read_word(2, 0);
    read_word(3, 4);
    finish_done();
    to_hw_sig = 2'b00;
    tick();
    // Abort while word 2 is presented.
    send(128'hcccc0003_bbbb0002_aaaa0001_99990000);
    read_word(0, 0);
    read_word(1, 0);
    wait_sig("abort_wait", 2'b01);
    chk("abort_idx_pre", {30'd0, word_idx}, 32'd2);
    to_hw_sig = 2'b11;
    tick();
    chk("abort_sig", {30'd0, to_sw_sig}, 32'd0);
    chk("abort_port", to_sw_port, 32'd0);
    chk("abort_idx", {30'd0, word_idx}, 32'd0);
    result_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("abort_hold_ready", {31'd0, result_ready}, 32'd0);
      chk("abort_hold_sig", {30'd0, to_sw_sig}, 32'd0);
    end
    result_valid = 1'b0;
    to_hw_sig = 2'b00;
    tick();
    chk("abort_rearm", {31'd0, result_ready}, 32'd1);
    send(128'h0f0f0f0f_f0f0f0f0_12345678_9abcdef0);
    for (int k = 0; k < 4; k++) read_word(k, k);
    finish_done();
    // Re-arm guard: stale done-ack must block acceptance.
    result_data = 128'h1;
    result_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("guard_ready", {31'd0, result_ready}, 32'd0);
      chk("guard_sig", {30'd0, to_sw_sig}, 32'd0);
    end
    result_valid = 1'b0;
    to_hw_sig = 2'b00;
    tick();
    chk("guard_rearm", {31'd0, result_ready}, 32'd1);
    send(128'h00000004_00000003_00000002_0000abcd);
    chk("guard_w0", to_sw_port, 32'h0000abcd);
    for (int k = 0; k < 4; k++) read_word(k, 0);
    finish_done();
    to_hw_sig = 2'b00;
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
